// File: rtl/bcd_counter_multi_led.sv
// Multi-digit BCD up/down counter for driving board LEDs.
// A free-running prescaler, gated by en_i, produces a one-cycle count tick.
// The block uses no derived clocks. Digits ripple through a combinational
// all-nines / all-zeros chain, so every digit updates on the same edge.
module bcd_counter_multi_led #(
    parameter int DIGITS  = 2,
    parameter int DIV_MAX = 49_999_999,
    parameter int DIV_W   = 26
) (
    input  logic                  clk_i,
    input  logic                  rst_i,          // asynchronous, active low
    input  logic                  en_i,
    input  logic                  up_i,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   load_val_i,
    output logic [4*DIGITS-1:0]   count_led_o,
    output logic                  carry_led_o,
    output logic                  tick_out_o,
    output logic                  wrap_o
);

    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(DIV_MAX);

    logic [DIV_W-1:0]    div_q, div_d;
    logic [4*DIGITS-1:0] cnt_q, cnt_d;
    logic                tick_q, tick_d;
    logic                wrap_q, wrap_d;
    logic                tick;
    logic                all9, all0;

    assign tick = en_i && (div_q == DIV_TC);

    // Terminal-value detection on the registered count
    always_comb begin
        all9 = 1'b1;
        all0 = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q[4*i +: 4] != 4'd9) all9 = 1'b0;
            if (cnt_q[4*i +: 4] != 4'd0) all0 = 1'b0;
        end
    end

    // Prescaler next state: load clears, terminal wraps to zero, en_i low holds
    always_comb begin
        div_d = div_q;
        if (load_i)
            div_d = '0;
        else if (tick)
            div_d = '0;
        else if (en_i)
            div_d = div_q + DIV_W'(1);
    end

    // Digit next state: load (non-BCD nibbles become 0) beats tick beats hold
    always_comb begin
        logic [3:0] dig;
        logic [3:0] ld;
        logic       ripple;
        cnt_d  = cnt_q;
        dig    = 4'd0;
        ld     = 4'd0;
        ripple = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            dig = cnt_q[4*i +: 4];
            ld  = load_val_i[4*i +: 4];
            if (load_i) begin
                cnt_d[4*i +: 4] = (ld > 4'd9) ? 4'd0 : ld;
            end else if (tick && ripple) begin
                if (up_i)
                    cnt_d[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
                else
                    cnt_d[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
            end
            // Higher digits only move when every lower digit is rolling over
            ripple = ripple && (up_i ? (dig == 4'd9) : (dig == 4'd0));
        end
        tick_d = !load_i && tick;
        wrap_d = tick_d && (up_i ? all9 : all0);
    end

    // State registers; pulses are registered so they align with the new count
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            div_q  <= '0;
            cnt_q  <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    assign count_led_o = cnt_q;
    assign carry_led_o = up_i ? all9 : all0;
    assign tick_out_o  = tick_q;
    assign wrap_o      = wrap_q;

endmodule

// File: tb/tb_bcd_counter_multi_led.sv
module tb_bcd_counter_multi_led;

    localparam int DIGITS  = 2;
    localparam int DIV_MAX = 3;
    localparam int DIV_W   = 4;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] count_led;
    logic       carry_led;
    logic       tick_out;
    logic       wrap;

    int checks   = 0;
    int failures = 0;

    bcd_counter_multi_led #(
        .DIGITS (DIGITS),
        .DIV_MAX(DIV_MAX),
        .DIV_W  (DIV_W)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .up_i       (up),
        .load_i     (load),
        .load_val_i (load_val),
        .count_led_o(count_led),
        .carry_led_o(carry_led),
        .tick_out_o (tick_out),
        .wrap_o     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] v);
        load_val = v;
        load     = 1'b1;
        cyc(1);
        load     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
        cyc(2);
        checks++;
        if (count_led !== 8'h00 || tick_out !== 1'b0 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: count=%h tick=%b wrap=%b, want 00/0/0", count_led, tick_out, wrap);
        end
        checks++;
        if (carry_led !== 1'b0) begin
            failures++;
            $display("FAIL reset_carry_up: got %b want 0", carry_led);
        end
        up = 1'b0;
        #1;
        checks++;
        if (carry_led !== 1'b1) begin
            failures++;
            $display("FAIL reset_carry_down: got %b want 1", carry_led);
        end
        up = 1'b1;
    endtask

    task automatic test_first_ticks();
        rst = 1'b1;
        en  = 1'b1;
        cyc(3);
        checks++;
        if (count_led !== 8'h00 || tick_out !== 1'b0) begin
            failures++;
            $display("FAIL first_tick_early: count=%h tick=%b, want 00/0", count_led, tick_out);
        end
        cyc(1);
        checks++;
        if (count_led !== 8'h01 || tick_out !== 1'b1) begin
            failures++;
            $display("FAIL first_tick: count=%h tick=%b, want 01/1", count_led, tick_out);
        end
        cyc(1);
        checks++;
        if (count_led !== 8'h01 || tick_out !== 1'b0) begin
            failures++;
            $display("FAIL tick_one_cycle: count=%h tick=%b, want 01/0", count_led, tick_out);
        end
        cyc(3);
        checks++;
        if (count_led !== 8'h02 || tick_out !== 1'b1) begin
            failures++;
            $display("FAIL second_tick: count=%h tick=%b, want 02/1", count_led, tick_out);
        end
    endtask

    task automatic test_up_wrap();
        up = 1'b1;
        do_load(8'h98);
        checks++;
        if (count_led !== 8'h98 || tick_out !== 1'b0) begin
            failures++;
            $display("FAIL load_98: count=%h tick=%b, want 98/0", count_led, tick_out);
        end
        cyc(4);
        checks++;
        if (count_led !== 8'h99 || carry_led !== 1'b1 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL up_to_99: count=%h carry=%b wrap=%b, want 99/1/0", count_led, carry_led, wrap);
        end
        cyc(4);
        checks++;
        if (count_led !== 8'h00 || wrap !== 1'b1 || tick_out !== 1'b1 || carry_led !== 1'b0) begin
            failures++;
            $display("FAIL up_wrap: count=%h wrap=%b tick=%b carry=%b, want 00/1/1/0", count_led, wrap, tick_out, carry_led);
        end
        cyc(1);
        checks++;
        if (wrap !== 1'b0) begin
            failures++;
            $display("FAIL up_wrap_pulse: wrap=%b want 0", wrap);
        end
    endtask

    task automatic test_down_wrap();
        up = 1'b0;
        do_load(8'h10);
        checks++;
        if (count_led !== 8'h10 || carry_led !== 1'b0) begin
            failures++;
            $display("FAIL load_10: count=%h carry=%b, want 10/0", count_led, carry_led);
        end
        cyc(4);
        checks++;
        if (count_led !== 8'h09 || tick_out !== 1'b1) begin
            failures++;
            $display("FAIL down_borrow: count=%h tick=%b, want 09/1", count_led, tick_out);
        end
        cyc(36);
        checks++;
        if (count_led !== 8'h00 || carry_led !== 1'b1 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL down_to_00: count=%h carry=%b wrap=%b, want 00/1/0", count_led, carry_led, wrap);
        end
        cyc(4);
        checks++;
        if (count_led !== 8'h99 || wrap !== 1'b1 || carry_led !== 1'b0) begin
            failures++;
            $display("FAIL down_wrap: count=%h wrap=%b carry=%b, want 99/1/0", count_led, wrap, carry_led);
        end
        cyc(1);
        checks++;
        if (wrap !== 1'b0 || count_led !== 8'h99) begin
            failures++;
            $display("FAIL down_wrap_pulse: count=%h wrap=%b, want 99/0", count_led, wrap);
        end
    endtask

    task automatic test_load();
        up = 1'b1;
        do_load(8'h3C);
        checks++;
        if (count_led !== 8'h30) begin
            failures++;
            $display("FAIL load_3c: count=%h want 30", count_led);
        end
        do_load(8'hA5);
        checks++;
        if (count_led !== 8'h05) begin
            failures++;
            $display("FAIL load_a5: count=%h want 05", count_led);
        end
        cyc(3);
        // next edge is a tick edge; load must win
        do_load(8'h42);
        checks++;
        if (count_led !== 8'h42 || tick_out !== 1'b0 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL load_on_tick: count=%h tick=%b wrap=%b, want 42/0/0", count_led, tick_out, wrap);
        end
        cyc(4);
        checks++;
        if (count_led !== 8'h43 || tick_out !== 1'b1) begin
            failures++;
            $display("FAIL after_load_tick: count=%h tick=%b, want 43/1", count_led, tick_out);
        end
    endtask

    task automatic test_pause();
        logic saw_tick;
        up = 1'b1;
        do_load(8'h20);
        cyc(2);
        en = 1'b0;
        saw_tick = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (tick_out !== 1'b0) saw_tick = 1'b1;
        end
        checks++;
        if (count_led !== 8'h20 || saw_tick !== 1'b0) begin
            failures++;
            $display("FAIL pause_hold: count=%h saw_tick=%b, want 20/0", count_led, saw_tick);
        end
        en = 1'b1;
        cyc(1);
        checks++;
        if (count_led !== 8'h20 || tick_out !== 1'b0) begin
            failures++;
            $display("FAIL resume_early: count=%h tick=%b, want 20/0", count_led, tick_out);
        end
        cyc(1);
        checks++;
        if (count_led !== 8'h21 || tick_out !== 1'b1) begin
            failures++;
            $display("FAIL resume_tick: count=%h tick=%b, want 21/1", count_led, tick_out);
        end
    endtask

    task automatic test_reset_mid();
        up = 1'b1;
        do_load(8'h57);
        cyc(2);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (count_led !== 8'h00 || tick_out !== 1'b0 || wrap !== 1'b0 || carry_led !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: count=%h tick=%b wrap=%b carry=%b, want 00/0/0/0", count_led, tick_out, wrap, carry_led);
        end
        cyc(1);
        rst = 1'b1;
        cyc(3);
        checks++;
        if (count_led !== 8'h00) begin
            failures++;
            $display("FAIL reset_release_early: count=%h want 00", count_led);
        end
        cyc(1);
        checks++;
        if (count_led !== 8'h01 || tick_out !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_tick: count=%h tick=%b, want 01/1", count_led, tick_out);
        end
    endtask

    initial begin
        test_reset();
        test_first_ticks();
        test_up_wrap();
        test_down_wrap();
        test_load();
        test_pause();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
